// File: rtl/layer_sequencer.sv
// Layer controller: buffers one input vector, broadcasts it to the neuron bank,
// gathers every neuron result and streams the results to the next layer.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_LOAD  | accept upstream words into the vector buffer
// ST_BURST | replay the buffer to all neurons as one gap-free valid burst
// ST_WAIT  | capture per-neuron results until all arrive or the timer expires
// ST_DRAIN | stream results downstream in neuron order
module layer_sequencer #(
   parameter int numWeight     = 784,
   parameter int numNeuron     = 30,
   parameter int dataWidth     = 16,
   parameter int timeoutCycles = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [dataWidth-1:0]           s_data,
   input  logic                           s_valid,
   output logic                           s_ready,
   output logic [dataWidth-1:0]           n_data,
   output logic                           n_valid,
   input  logic [numNeuron*dataWidth-1:0] n_out,
   input  logic [numNeuron-1:0]           n_outvalid,
   output logic [dataWidth-1:0]           m_data,
   output logic                           m_valid,
   input  logic                           m_ready,
   output logic                           busy,
   output logic                           err_timeout
);
   localparam int WW = $clog2(numWeight + 1);
   localparam int NW = $clog2(numNeuron + 1);
   localparam int TW = $clog2(timeoutCycles + 1);
   localparam int AW = (numWeight > 1) ? $clog2(numWeight) : 1;
   localparam int RA = (numNeuron > 1) ? $clog2(numNeuron) : 1;
   localparam logic [WW-1:0] W_LAST = WW'(numWeight - 1);
   localparam logic [WW-1:0] W_END  = WW'(numWeight);
   localparam logic [NW-1:0] N_LAST = NW'(numNeuron - 1);
   localparam logic [TW-1:0] T_LOAD = TW'(timeoutCycles);
   localparam logic [TW-1:0] T_TC   = TW'(1);

   typedef enum logic [1:0] {ST_LOAD, ST_BURST, ST_WAIT, ST_DRAIN} state_t;

   state_t                 state_q, state_d;
   logic [WW-1:0]          wcnt_q;
   logic [NW-1:0]          rcnt_q;
   logic [TW-1:0]          tmr_q;
   logic [numNeuron-1:0]   flag_q;
   logic [dataWidth-1:0]   res_q   [numNeuron];
   logic [dataWidth-1:0]   vec_buf [numWeight];
   logic                   s_ready_q, n_valid_q, err_q;
   logic [dataWidth-1:0]   n_data_q;
   logic                   s_hs, m_hs, flag_all, tmr_tc;

   assign s_hs     = s_valid & s_ready_q;
   assign m_hs     = m_valid & m_ready;
   assign flag_all = &(flag_q | n_outvalid);
   assign tmr_tc   = (tmr_q == T_TC);

   assign s_ready     = s_ready_q;
   assign n_valid     = n_valid_q;
   assign n_data      = n_data_q;
   assign m_valid     = (state_q == ST_DRAIN);
   assign m_data      = m_valid ? res_q[rcnt_q[RA-1:0]] : '0;
   assign busy        = !((state_q == ST_LOAD) && (wcnt_q == '0));
   assign err_timeout = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_LOAD;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD:  if (s_hs && wcnt_q == W_LAST)   state_d = ST_BURST;
         ST_BURST: if (wcnt_q == W_END)            state_d = ST_WAIT;
         ST_WAIT:  if (flag_all || tmr_tc)         state_d = ST_DRAIN;
         ST_DRAIN: if (m_hs && rcnt_q == N_LAST)   state_d = ST_LOAD;
         default:                                  state_d = ST_LOAD;
      endcase
   end

   // Vector storage has no reset so it can map onto a RAM with registered read.
   always_ff @(posedge clk) begin
      if (state_q == ST_LOAD && s_hs) vec_buf[wcnt_q[AW-1:0]] <= s_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt_q    <= '0;
         rcnt_q    <= '0;
         tmr_q     <= '0;
         flag_q    <= '0;
         s_ready_q <= 1'b0;
         n_valid_q <= 1'b0;
         n_data_q  <= '0;
         err_q     <= 1'b0;
         for (int k = 0; k < numNeuron; k++) res_q[k] <= '0;
      end else begin
         s_ready_q <= (state_d == ST_LOAD);
         n_valid_q <= 1'b0;
         n_data_q  <= '0;
         case (state_q)
            ST_LOAD: begin
               if (s_hs) wcnt_q <= (wcnt_q == W_LAST) ? '0 : wcnt_q + 1'b1;
            end
            ST_BURST: begin
               // wcnt runs one past the last read so BURST covers the final n_valid cycle
               if (wcnt_q != W_END) begin
                  n_valid_q <= 1'b1;
                  n_data_q  <= vec_buf[wcnt_q[AW-1:0]];
                  wcnt_q    <= wcnt_q + 1'b1;
               end else begin
                  wcnt_q <= '0;
                  flag_q <= '0;
                  tmr_q  <= T_LOAD;
               end
            end
            ST_WAIT: begin
               for (int k = 0; k < numNeuron; k++) begin
                  if (n_outvalid[k]) begin
                     res_q[k]  <= n_out[k*dataWidth +: dataWidth];
                     flag_q[k] <= 1'b1;
                  end else if (tmr_tc && !flag_all && !flag_q[k]) begin
                     res_q[k] <= '0;
                  end
               end
               if (!flag_all) begin
                  if (tmr_tc) err_q <= 1'b1;
                  else        tmr_q <= tmr_q - 1'b1;
               end
            end
            ST_DRAIN: begin
               if (m_hs) rcnt_q <= (rcnt_q == N_LAST) ? '0 : rcnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Per-layer controller for a bank of numNeuron neuron instances that share one broadcast input bus.
- Buffers one input vector of numWeight words from the upstream stream.
- Replays the buffered vector to all neurons as a single contiguous valid burst.
- Collects every neuron result, then serialises the results downstream as a valid/ready stream that feeds the next layer's sequencer.

Parameters:
- numWeight, 784, input vector length (neuron weight count).
- numNeuron, 30, number of neurons in the layer.
- dataWidth, 16, word width of every data path.
- timeoutCycles, 64, maximum WAIT cycles before results are forced out.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- s_data  in  dataWidth  upstream input word.
- s_valid  in  1  upstream word valid.
- s_ready  out  1  sequencer accepts an upstream word.
- n_data  out  dataWidth  broadcast word to all neurons (neuron myinput).
- n_valid  out  1  broadcast valid (neuron myinputValid).
- n_out  in  numNeuron*dataWidth  concatenated neuron outputs; neuron k is bits [k*dataWidth +: dataWidth].
- n_outvalid  in  numNeuron  per-neuron outvalid.
- m_data  out  dataWidth  downstream result word.
- m_valid  out  1  downstream word valid.
- m_ready  in  1  downstream accepts.
- busy  out  1  high in every state except LOAD with zero words buffered.
- err_timeout  out  1  sticky; set when WAIT times out.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=LOAD; all counters 0; capture flags cleared.
  - s_ready=0, n_valid=0, n_data=0, m_valid=0, m_data=0, busy=0, err_timeout=0.
  - After release, s_ready=1 from the first clk edge.
  - Reset mid-burst or mid-drain aborts with no further n_valid/m_valid pulses.
- States: LOAD -> BURST -> WAIT -> DRAIN -> LOAD.
- LOAD:
  - s_ready=1. Each handshake (s_valid&s_ready) writes buf[wcnt] and increments wcnt.
  - On the handshake with wcnt==numWeight-1: go to BURST and set wcnt=0.
  - s_ready is 0 from the cycle after that handshake.
- BURST:
  - The first n_valid occurs exactly 2 cycles after the final LOAD handshake (allows a registered buffer read).
  - n_valid stays high for exactly numWeight consecutive cycles, with n_data=buf[0..numWeight-1] in order and no gaps.
  - In the cycle after the last n_valid: n_valid=0, n_data=0, enter WAIT, clear the capture flags and the timeout counter.
- WAIT:
  - For each k with n_outvalid[k]=1: capture n_out slice k into res[k] and set flag[k].
  - A repeat outvalid for an already-flagged k overwrites res[k].
  - Once all flags are set (counting same-cycle captures): go to DRAIN next cycle.
  - The timeout counter increments every WAIT cycle. On reaching timeoutCycles with flags incomplete: set err_timeout, load unflagged res[k]=0, go to DRAIN.
  - n_outvalid outside WAIT is ignored.
- DRAIN:
  - m_valid=1, m_data=res[rcnt], starting at rcnt=0.
  - m_data/m_valid stay stable while m_ready=0 (AXI-stream rule; m_valid never drops without a handshake).
  - Each handshake increments rcnt.
  - On the handshake at rcnt==numNeuron-1: m_valid=0 next cycle, state=LOAD, s_ready=1 that same next cycle.
  - No overlap: s_ready=0 throughout DRAIN, even if s_valid is already high.
- Widths: counters are $clog2(numWeight+1) and $clog2(numNeuron+1) bits; the timeout counter is $clog2(timeoutCycles+1) bits. No arithmetic is performed on data words.
- err_timeout clears only on reset.

Test Plan (numWeight=4, numNeuron=3, dataWidth=16, timeoutCycles=8 unless stated):
- Basic pass:
  - Stimulus: s words 0x0001..0x0004 back-to-back; neuron model asserts all outvalid 5 cycles after the last n_valid with outs 0x0A,0x0B,0x0C; m_ready=1.
  - Response: n_valid high 4 consecutive cycles, starting 2 cycles after the last s handshake, with n_data 1,2,3,4. m_data sequence 0x0A,0x0B,0x0C on consecutive cycles, then s_ready=1.
- Staggered results with backpressure:
  - Stimulus: outvalid for neurons 2,0,1 on separate cycles; m_ready toggled 1,0,0,1,...
  - Response: m_data holds value while stalled; order is still res[0],res[1],res[2]; err_timeout=0.
- Timeout:
  - Stimulus: neuron 1 never asserts outvalid.
  - Response: 8 cycles into WAIT, err_timeout=1; drain outputs res[0], 0x0000, res[2]; next vector processes normally with err_timeout still 1.
- Gappy upstream:
  - Stimulus: s_valid pattern 1,0,1,1,0,1.
  - Response: exactly 4 words buffered; n_valid burst is still gap-free.
- Reset mid-burst:
  - Stimulus: rst=0 during the 2nd n_valid cycle.
  - Response: n_valid=0 immediately (asynchronous); after release s_ready=1, busy=0; a fresh vector gives correct results.
- Early upstream:
  - Stimulus: s_valid held high during DRAIN.
  - Response: no s handshake until the cycle after the last m handshake.
